// File: rtl/wb_pkg.sv
// Shared writeback-buffer constants and entry type.
// Default widths/depth and the {addr, data} entry record.
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_match.sv
// Newest-match lookup over the pending writeback entries.
// Ports: valid/ent_addr/ent_data entries, head ptr, lk_addr in; hit/fwd out.
module wb_match
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] ent_data,
  input  logic [PTR_W-1:0]             head,
  input  logic [ADDR_W-1:0]            lk_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            fwd
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to newest; the last match seen is the newest.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (valid[idx] &&
          ent_addr[idx] == lk_addr) begin
        hit = 1'b1;
        fwd = ent_data[idx];
      end
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// In-order writeback buffer draining into the register file write port.
// Ports: wb_* push side, rf_* drain side, o*/hit*/fwd* bypass, count.
module wb_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic                    rf_stall,
  output logic                    rf_write,
  output logic [ADDR_W-1:0]       rf_in_addr,
  output logic [DATA_W-1:0]       rf_in,
  input  logic [ADDR_W-1:0]       o1_addr,
  input  logic [ADDR_W-1:0]       o2_addr,
  output logic                    hit1,
  output logic                    hit2,
  output logic [DATA_W-1:0]       fwd1,
  output logic [DATA_W-1:0]       fwd2,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]             head_q, head_d;
  logic [PTR_W-1:0]             tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

  logic push;
  logic pop;
  logic empty;

  assign empty    = (count_q == '0);
  // Full blocks pushes even when a pop frees a slot this cycle.
  assign wb_ready = (count_q < CNT_W'(DEPTH));
  assign rf_write = !empty && !rf_stall;
  assign push     = wb_valid && wb_ready;
  assign pop      = rf_write;
  assign count    = count_q;

  assign rf_in_addr = empty ? '0 : addr_q[head_q];
  assign rf_in      = empty ? '0 : data_q[head_q];

  // Push and pop never touch the same slot: push needs
  // non-full, pop needs non-empty, so head != tail then.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (push) begin
      addr_d[tail_q]  = wb_addr;
      data_d[tail_q]  = wb_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    count_d = count_q + CNT_W'(push)
                      - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload storage is qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  wb_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_match1 (
    .valid    (valid_q),
    .ent_addr (addr_q),
    .ent_data (data_q),
    .head     (head_q),
    .lk_addr  (o1_addr),
    .hit      (hit1),
    .fwd      (fwd1)
  );

  wb_match #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_match2 (
    .valid    (valid_q),
    .ent_addr (addr_q),
    .ent_data (data_q),
    .head     (head_q),
    .lk_addr  (o2_addr),
    .hit      (hit2),
    .fwd      (fwd2)
  );

endmodule

// File: tb/tb_wb_buffer.sv
// Directed self-checking bench for wb_buffer.
// Drives push/stall/lookup vectors and checks hand-computed results.
module tb_wb_buffer;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_stall;
  logic        rf_write;
  logic [4:0]  rf_in_addr;
  logic [31:0] rf_in;
  logic [4:0]  o1_addr;
  logic [4:0]  o2_addr;
  logic        hit1;
  logic        hit2;
  logic [31:0] fwd1;
  logic [31:0] fwd2;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_buffer u_dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .rf_stall   (rf_stall),
    .rf_write   (rf_write),
    .rf_in_addr (rf_in_addr),
    .rf_in      (rf_in),
    .o1_addr    (o1_addr),
    .o2_addr    (o2_addr),
    .hit1       (hit1),
    .hit2       (hit2),
    .fwd1       (fwd1),
    .fwd2       (fwd2),
    .count      (count)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are
  // sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
  endtask

  initial begin
    rst      = 1'b1;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;
    rf_stall = 1'b0;
    o1_addr  = '0;
    o2_addr  = '0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_ready", 32'(wb_ready), 1);
    check("rst_write", 32'(rf_write), 0);
    check("rst_in_addr", 32'(rf_in_addr), 0);
    check("rst_in", rf_in, 0);
    check("rst_hit1", 32'(hit1), 0);
    check("rst_hit2", 32'(hit2), 0);
    check("rst_fwd1", fwd1, 0);
    check("rst_fwd2", fwd2, 0);
    check("rst_count", 32'(count), 0);

    // Basic drain
    o1_addr = 5'd30;
    push(5'd30, 32'd111111);
    #1;
    check("drn_same_cyc_hit", 32'(hit1), 0);
    check("drn_same_cyc_wr", 32'(rf_write), 0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("drn_write", 32'(rf_write), 1);
    check("drn_addr", 32'(rf_in_addr), 30);
    check("drn_data", rf_in, 111111);
    check("drn_hit1", 32'(hit1), 1);
    check("drn_fwd1", fwd1, 111111);
    check("drn_count1", 32'(count), 1);
    tick();
    check("drn_count0", 32'(count), 0);
    check("drn_idle_wr", 32'(rf_write), 0);
    check("drn_idle_hit", 32'(hit1), 0);
    check("drn_idle_in", rf_in, 0);

    // Forwarding priority
    rf_stall = 1'b1;
    o1_addr  = 5'd10;
    o2_addr  = 5'd10;
    push(5'd10, 32'd5);
    tick();
    push(5'd10, 32'd9999999);
    tick();
    wb_valid = 1'b0;
    #1;
    check("fp_stall_wr", 32'(rf_write), 0);
    check("fp_count", 32'(count), 2);
    check("fp_hit2", 32'(hit2), 1);
    check("fp_fwd2", fwd2, 9999999);
    check("fp_fwd1", fwd1, 9999999);
    rf_stall = 1'b0;
    #1;
    check("fp_wr0", 32'(rf_write), 1);
    check("fp_addr0", 32'(rf_in_addr), 10);
    check("fp_data0", rf_in, 5);
    tick();
    check("fp_wr1", 32'(rf_write), 1);
    check("fp_data1", rf_in, 9999999);
    check("fp_fwd2_b", fwd2, 9999999);
    tick();
    check("fp_count0", 32'(count), 0);
    check("fp_hit2_0", 32'(hit2), 0);
    check("fp_fwd2_0", fwd2, 0);

    // Full, including register address 0
    rf_stall = 1'b1;
    o1_addr  = 5'd0;
    for (int i = 0; i < 5; i++) begin
      push(5'(i), 32'(100 + i));
      #1;
      check($sformatf("full_ready%0d", i),
            32'(wb_ready), (i < 4) ? 1 : 0);
      tick();
    end
    wb_valid = 1'b0;
    #1;
    check("full_count", 32'(count), 4);
    check("full_ready", 32'(wb_ready), 0);
    check("full_stall_wr", 32'(rf_write), 0);
    check("full_hit_a0", 32'(hit1), 1);
    check("full_fwd_a0", fwd1, 100);
    rf_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("full_wr%0d", i),
            32'(rf_write), 1);
      check($sformatf("full_addr%0d", i),
            32'(rf_in_addr), i);
      check($sformatf("full_data%0d", i),
            rf_in, 100 + i);
      tick();
    end
    check("full_count0", 32'(count), 0);
    check("full_wr_end", 32'(rf_write), 0);

    // Simultaneous push/pop across pointer wrap
    rf_stall = 1'b1;
    push(5'd20, 32'd1000);
    tick();
    push(5'd21, 32'd1001);
    tick();
    rf_stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      push(5'(22 + k), 32'(1002 + k));
      #1;
      check($sformatf("pp_count%0d", k),
            32'(count), 2);
      check($sformatf("pp_data%0d", k),
            rf_in, 1000 + k);
      check($sformatf("pp_addr%0d", k),
            32'(rf_in_addr), 20 + k);
      tick();
    end
    wb_valid = 1'b0;
    #1;
    check("pp_tail_d0", rf_in, 1008);
    tick();
    check("pp_tail_d1", rf_in, 1009);
    tick();
    check("pp_count0", 32'(count), 0);

    // Reset mid-operation
    rf_stall = 1'b1;
    o1_addr  = 5'd7;
    o2_addr  = 5'd9;
    push(5'd7, 32'd7000);
    tick();
    push(5'd8, 32'd7001);
    tick();
    push(5'd9, 32'd7002);
    tick();
    wb_valid = 1'b0;
    #1;
    check("mr_count3", 32'(count), 3);
    check("mr_hit1_pre", 32'(hit1), 1);
    rst = 1'b1;
    push(5'd9, 32'd7003);
    tick();
    rst      = 1'b0;
    wb_valid = 1'b0;
    rf_stall = 1'b0;
    #1;
    check("mr_wr", 32'(rf_write), 0);
    check("mr_count", 32'(count), 0);
    check("mr_hit1", 32'(hit1), 0);
    check("mr_hit2", 32'(hit2), 0);
    check("mr_in", rf_in, 0);
    check("mr_ready", 32'(wb_ready), 1);
    tick();
    check("mr_wr_later", 32'(rf_write), 0);
    check("mr_in_later", rf_in, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_buffer.md
WB_BUFFER -- requirements
Module: wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffered writeback entries (power of two, 2..16).
REQ-002 SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-003 SHALL have parameter ADDR_W, default 5, meaning register address width (32 registers).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port wb_valid  input  1  writeback request from execute stage.
REQ-007 SHALL have port wb_ready  output  1  buffer can accept a request this cycle.
REQ-008 SHALL have port wb_addr  input  ADDR_W  destination register address.
REQ-009 SHALL have port wb_data  input  DATA_W  value to write.
REQ-010 SHALL have port rf_stall  input  1  register file write port unavailable this cycle.
REQ-011 SHALL have port rf_write  output  1  write strobe to the register file.
REQ-012 SHALL have port rf_in_addr  output  ADDR_W  register file write address.
REQ-013 SHALL have port rf_in  output  DATA_W  register file write data.
REQ-014 SHALL have ports o1_addr, o2_addr  input  ADDR_W each  operand read addresses, the same ones presented to the register file.
REQ-015 SHALL have ports hit1, hit2  output  1 each  a pending entry matches o1_addr/o2_addr.
REQ-016 SHALL have ports fwd1, fwd2  output  DATA_W each  forwarded value for o1_addr/o2_addr.
REQ-017 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-018 SHALL store entries in arrival order: circular buffer with head pointer, tail pointer and count.
REQ-019 SHALL drive wb_ready = (count < DEPTH) combinationally.
  - No pass-through when full, even if a pop occurs in the same cycle.
REQ-020 SHALL push {wb_addr, wb_data} at the tail on a rising edge where wb_valid && wb_ready.
REQ-021 SHALL drive rf_write = (count != 0) && !rf_stall combinationally.
  - rf_in_addr/rf_in SHALL be the head entry whenever count != 0, and 0 when empty.
REQ-022 SHALL pop the head on every edge where rf_write=1.
  - Drain rate: one entry per cycle; in-order; no coalescing of same-address entries.
REQ-023 SHALL handle simultaneous push and pop in one edge: count unchanged, both pointers advance.
REQ-024 SHALL wrap pointers from DEPTH-1 to 0.
REQ-025 SHALL make a pushed entry visible no earlier than the cycle after its push edge.
  - Minimum push-to-rf_write latency: 1 cycle.
  - Push-to-hit latency: 1 cycle.
REQ-026 SHALL compute hitN/fwdN combinationally over all occupied entries, including the head being drained that cycle.
  - The newest matching entry (closest to tail) wins.
  - Incoming wb_* of the same cycle SHALL NOT be considered.
REQ-027 SHALL drive hitN=0 and fwdN=0 when there is no match.
REQ-028 SHALL treat address 0 like any other address (no hardwired zero register).
REQ-029 SHALL hold all state, with rf_write=0, while rf_stall=1, and continue accepting pushes until full.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, clear count, head and tail to 0 and all entry valid bits.
  - Entry data is not reset.
REQ-031 SHALL drive these values from the cycle after reset while empty: wb_ready=1, rf_write=0, rf_in_addr=0, rf_in=0, hit1=hit2=0, fwd1=fwd2=0, count=0.
REQ-032 SHALL give rst priority over simultaneous push and pop; a reset mid-operation discards all pending entries without issuing writes.

Structure
REQ-033 SHALL place DATA_W, ADDR_W and DEPTH default constants, plus a wb_entry_t typedef {addr, data}, in shared package wb_pkg.
REQ-034 SHALL implement the newest-match lookup as sub-module wb_match, instantiated twice (operand 1, operand 2).
REQ-035 SHALL be synthesizable in 120-400 lines of RTL, with no latches and no asynchronous logic.

Verification
REQ-036 SHALL cover basic drain: push (30, 111111) into an empty buffer -> next cycle rf_write=1, rf_in_addr=30, rf_in=111111, hit1=1 for o1_addr=30; following cycle count=0.
REQ-037 SHALL cover forwarding priority: with rf_stall=1, push (10, 5) then (10, 9999999) -> hit2=1, fwd2=9999999 for o2_addr=10; release stall -> rf writes 5 then 9999999 in order.
REQ-038 SHALL cover full: with rf_stall=1, push 5 requests -> wb_ready=0 after the 4th, 5th not accepted, count=4; release stall -> 4 writes in order, then count=0.
REQ-039 SHALL cover simultaneous push/pop: count=2, steady wb_valid=1 with rf_stall=0 -> count stays 2 each cycle; rf_in order matches push order across pointer wrap.
REQ-040 SHALL cover reset mid-operation: count=3, assert rst for one edge -> rf_write=0, count=0, hit1=hit2=0 next cycle; no pending entry ever appears on rf_in.
